// File: rtl/ordenador_bolha.sv
// ordenador_bolha: valid/ready bubble sorter for N unsigned W-bit words.
// One shared A > B comparison per SORT cycle; each pass stops early once it makes no swap.
module ordenador_bolha #(
   parameter int W = 4,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   input  logic [W-1:0] in_data_i,
   output logic         in_ready_o,
   output logic         out_valid_o,
   output logic [W-1:0] out_data_o,
   input  logic         out_ready_i,
   output logic         busy_o
);
   localparam int IW = (N > 2) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic [IW-1:0] PMAX = IW'(N - 2);
   typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;
   state_t state_q, state_d;
   logic [W-1:0] mem_q [N];
   logic [W-1:0] mem_d [N];
   logic [IW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, p_q, p_d, i_q, i_d, nxt;
   logic swapped_q, swapped_d, gt, any_swap;
   logic [W-1:0] a, b;
   assign in_ready_o  = state_q == LOAD;
   assign out_valid_o = state_q == OUT;
   assign busy_o      = state_q == SORT;
   assign out_data_o  = mem_q[rcnt_q];
   always_comb begin
      nxt       = i_q + 1'b1;
      a         = mem_q[i_q];
      b         = mem_q[nxt];
      gt        = a > b;
      any_swap  = swapped_q | gt;
      state_d   = state_q;
      mem_d     = mem_q;
      wcnt_d    = wcnt_q;
      rcnt_d    = rcnt_q;
      p_d       = p_q;
      i_d       = i_q;
      swapped_d = swapped_q;
      case (state_q)
         LOAD: if (in_valid_i) begin
            mem_d[wcnt_q] = in_data_i;
            wcnt_d        = wcnt_q + 1'b1;
            if (wcnt_q == LAST) begin
               state_d   = SORT;
               wcnt_d    = '0;
               p_d       = '0;
               i_d       = '0;
               swapped_d = 1'b0;
            end
         end
         SORT: begin
            if (gt) begin
               mem_d[i_q] = b;
               mem_d[nxt] = a;
            end
            swapped_d = any_swap;
            if (i_q < PMAX - p_q) i_d = nxt;
            // a clean pass means sorted; pass N-2 is the last one ever needed
            else if (!any_swap || p_q == PMAX) begin
               state_d = OUT;
               rcnt_d  = '0;
            end else begin
               p_d       = p_q + 1'b1;
               i_d       = '0;
               swapped_d = 1'b0;
            end
         end
         OUT: if (out_ready_i) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == LAST) begin
               state_d = LOAD;
               wcnt_d  = '0;
               rcnt_d  = '0;
            end
         end
         default: state_d = LOAD;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LOAD;
         mem_q     <= '{default: '0};
         wcnt_q    <= '0;
         rcnt_q    <= '0;
         p_q       <= '0;
         i_q       <= '0;
         swapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_q     <= mem_d;
         wcnt_q    <= wcnt_d;
         rcnt_q    <= rcnt_d;
         p_q       <= p_d;
         i_q       <= i_d;
         swapped_q <= swapped_d;
      end
   end
endmodule

// File: tb/tb_ordenador_bolha.sv
// tb_ordenador_bolha: scoreboard bench for ordenador_bolha (W=4, N=4).
// Expected outputs come from sorting each block with the queue sort() method.
module tb_ordenador_bolha;
   typedef logic [3:0] blk_t [4];
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] in_data = '0;
   logic in_ready, out_valid, busy;
   logic [3:0] out_data;
   int total = 0, bad = 0, cyc = 0, t_acc = 0, busy_cnt = 0;
   logic [3:0] exp_q [$];

   ordenador_bolha #(.W(4), .N(4)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
      .out_ready_i(out_ready), .busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // scoreboard monitor: a word is consumed at the edge following this sample
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_output", int'(out_data), -1);
         else chk("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
   end

   // called just after a rising edge; returns just after the edge that took the last word
   task automatic load_block(input blk_t w, input bit gaps, input bit hold, input bit push);
      logic [3:0] s [$];
      int n;
      busy_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_data  = w[k];
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!in_ready && n < 100);
         if (!in_ready) chk("load_timeout", 0, 1);
         @(posedge clk);
         #1;
         t_acc    = cyc;
         in_valid = 1'b0;
      end
      if (hold) begin
         in_valid = 1'b1;
         in_data  = 4'd15;
      end
      if (push) begin
         foreach (w[k]) s.push_back(w[k]);
         s.sort();
         foreach (s[k]) exp_q.push_back(s[k]);
      end
   endtask

   task automatic wait_out(input int c);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      chk("latency", cyc - t_acc, c);
      chk("busy_cycles", busy_cnt, c);
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
      if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
      out_ready = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_out_data"}, int'(out_data), 0);
   endtask

   initial begin
      blk_t r;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle("reset");
      @(posedge clk);
      #1;
      // already sorted: one pass, no swaps
      load_block('{4'd1, 4'd2, 4'd3, 4'd4}, 0, 0, 1);
      wait_out(3);
      drain(0);
      // reverse order: worst case
      load_block('{4'd15, 4'd10, 4'd5, 4'd0}, 0, 0, 1);
      wait_out(6);
      drain(0);
      // duplicates and extremes: equal 7s never swap, so the second pass is clean
      load_block('{4'd7, 4'd0, 4'd7, 4'd15}, 0, 0, 1);
      wait_out(5);
      drain(0);
      // producer gaps, then consumer stall
      load_block('{4'd9, 4'd3, 4'd12, 4'd3}, 1, 0, 1);
      wait_out(6);
      repeat (5) begin
         @(negedge clk);
         chk("stall_out_valid", int'(out_valid), 1);
         chk("stall_out_data", int'(out_data), 3);
      end
      drain(0);
      // reset during the second SORT cycle
      load_block('{4'd4, 4'd3, 4'd2, 4'd1}, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle("midsort_reset");
      @(posedge clk);
      #1;
      load_block('{4'd2, 4'd1, 4'd4, 4'd3}, 0, 0, 1);
      drain(0);
      // in_valid held with 15 through SORT and OUT; that 15 becomes word 0 of the next block
      for (int k = 0; k < 4; k++) r[k] = 4'($urandom_range(0, 15));
      load_block(r, 0, 1, 1);
      drain(0);
      r[0] = 4'd15;
      for (int k = 1; k < 4; k++) r[k] = 4'($urandom_range(0, 15));
      load_block(r, 0, 0, 1);
      drain(0);
      // random blocks with random producer gaps and consumer stalls
      repeat (20) begin
         for (int k = 0; k < 4; k++) r[k] = 4'($urandom_range(0, 15));
         load_block(r, 1, 0, 1);
         drain(1);
      end
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
